// File: rtl/cla_group_carry_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : cla_group_carry_pipe_if
//  Purpose  : Operand/result handshake bundle for the pipelined group-carry
//             lookahead adder. The master side drives operands and OUT_READY;
//             the slave side (the adder) returns IN_READY and the result.
//  Revision : 1.0  initial release
// ============================================================================
interface cla_group_carry_pipe_if #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
);
  localparam int NG = (GROUP >= 1) ? (WIDTH / GROUP) : 1;

  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic [NG-1:0]    GG_OUT;
  logic [NG-1:0]    GP_OUT;

  modport master (
    output IN_VALID, A, B, CIN, OUT_READY,
    input  IN_READY, OUT_VALID, SUM, COUT, GG_OUT, GP_OUT
  );

  modport slave (
    input  IN_VALID, A, B, CIN, OUT_READY,
    output IN_READY, OUT_VALID, SUM, COUT, GG_OUT, GP_OUT
  );
endinterface
`default_nettype wire

// File: rtl/cla_group_carry_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : cla_group_carry_pipe
//  Purpose  : Exact 3-stage pipelined carry-lookahead adder. S1 forms bit and
//             group generate/propagate, S2 resolves the inter-group carries,
//             S3 ripples carries inside each group and registers the result.
//             Valid/ready on both sides, one result per cycle when unstalled.
//  Revision : 1.0  initial release
// ============================================================================
module cla_group_carry_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  cla_group_carry_pipe_if.slave bus
);

  localparam int GDIV = (GROUP >= 1) ? GROUP : 1;
  localparam int NG   = WIDTH / GDIV;

  if ((GROUP < 1) || ((WIDTH % GDIV) != 0)) begin : g_param_check
    $error("cla_group_carry_pipe: WIDTH must be a positive multiple of GROUP");
  end

  // Handshake: a stage may load when its own slot is empty or is being emptied.
  logic out_load;
  logic s2_load;
  logic s1_load;

  // Stage 1 state: bit g/p, group GG/GP and the carry-in.
  logic             s1_valid_d, s1_valid_q;
  logic             s1_cin_d,   s1_cin_q;
  logic [WIDTH-1:0] s1_g_d,     s1_g_q;
  logic [WIDTH-1:0] s1_p_d,     s1_p_q;
  logic [NG-1:0]    s1_gg_d,    s1_gg_q;
  logic [NG-1:0]    s1_gp_d,    s1_gp_q;

  // Stage 2 state: resolved group carries plus the forwarded g/p/GG/GP.
  logic             s2_valid_d, s2_valid_q;
  logic [WIDTH-1:0] s2_g_d,     s2_g_q;
  logic [WIDTH-1:0] s2_p_d,     s2_p_q;
  logic [NG:0]      s2_c_d,     s2_c_q;
  logic [NG-1:0]    s2_gg_d,    s2_gg_q;
  logic [NG-1:0]    s2_gp_d,    s2_gp_q;

  // Stage 3 state: the output register.
  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] sum_d,       sum_q;
  logic             cout_d,      cout_q;
  logic [NG-1:0]    gg_out_d,    gg_out_q;
  logic [NG-1:0]    gp_out_d,    gp_out_q;

  // Combinational helpers, one set per stage.
  logic [WIDTH-1:0] bit_g;
  logic [WIDTH-1:0] bit_p;
  logic [NG-1:0]    grp_gg;
  logic [NG-1:0]    grp_gp;
  logic             s1_run;
  logic             s1_allp;
  logic [NG:0]      grp_c;
  logic             s2_run;
  logic [WIDTH-1:0] bit_sum;
  logic             s3_run;

  assign out_load = !out_valid_q || bus.OUT_READY;
  assign s2_load  = !s2_valid_q  || out_load;
  assign s1_load  = !s1_valid_q  || s2_load;

  assign bus.IN_READY  = s1_load;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.SUM       = sum_q;
  assign bus.COUT      = cout_q;
  assign bus.GG_OUT    = gg_out_q;
  assign bus.GP_OUT    = gp_out_q;

  // S1: bit generate/propagate and per-group GG (carry-in 0 ripple) / GP.
  always_comb begin
    bit_g   = bus.A & bus.B;
    bit_p   = bus.A ^ bus.B;
    grp_gg  = '0;
    grp_gp  = '0;
    s1_run  = 1'b0;
    s1_allp = 1'b1;
    for (int k = 0; k < NG; k++) begin
      s1_run  = 1'b0;
      s1_allp = 1'b1;
      for (int i = 0; i < GDIV; i++) begin
        s1_run  = bit_g[k*GDIV+i] | (bit_p[k*GDIV+i] & s1_run);
        s1_allp = s1_allp & bit_p[k*GDIV+i];
      end
      grp_gg[k] = s1_run;
      grp_gp[k] = s1_allp;
    end

    s1_valid_d = s1_load ? bus.IN_VALID : s1_valid_q;
    s1_cin_d   = s1_cin_q;
    s1_g_d     = s1_g_q;
    s1_p_d     = s1_p_q;
    s1_gg_d    = s1_gg_q;
    s1_gp_d    = s1_gp_q;
    if (s1_load && bus.IN_VALID) begin
      s1_cin_d = bus.CIN;
      s1_g_d   = bit_g;
      s1_p_d   = bit_p;
      s1_gg_d  = grp_gg;
      s1_gp_d  = grp_gp;
    end
  end

  // S2: lookahead across groups, c[k+1] = GG[k] | GP[k] & c[k], c[0] = CIN.
  always_comb begin
    grp_c    = '0;
    s2_run   = s1_cin_q;
    grp_c[0] = s2_run;
    for (int k = 0; k < NG; k++) begin
      s2_run     = s1_gg_q[k] | (s1_gp_q[k] & s2_run);
      grp_c[k+1] = s2_run;
    end

    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    s2_g_d     = s2_g_q;
    s2_p_d     = s2_p_q;
    s2_c_d     = s2_c_q;
    s2_gg_d    = s2_gg_q;
    s2_gp_d    = s2_gp_q;
    if (s2_load && s1_valid_q) begin
      s2_g_d  = s1_g_q;
      s2_p_d  = s1_p_q;
      s2_c_d  = grp_c;
      s2_gg_d = s1_gg_q;
      s2_gp_d = s1_gp_q;
    end
  end

  // S3: ripple each group's carry from c[k] to form the sum; hold when stalled.
  always_comb begin
    bit_sum = '0;
    s3_run  = 1'b0;
    for (int k = 0; k < NG; k++) begin
      s3_run = s2_c_q[k];
      for (int i = 0; i < GDIV; i++) begin
        bit_sum[k*GDIV+i] = s2_p_q[k*GDIV+i] ^ s3_run;
        s3_run            = s2_g_q[k*GDIV+i] | (s2_p_q[k*GDIV+i] & s3_run);
      end
    end

    out_valid_d = out_load ? s2_valid_q : out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    gg_out_d    = gg_out_q;
    gp_out_d    = gp_out_q;
    if (out_load && s2_valid_q) begin
      sum_d    = bit_sum;
      cout_d   = s2_c_q[NG];
      gg_out_d = s2_gg_q;
      gp_out_d = s2_gp_q;
    end
  end

  // Pipeline registers with synchronous active-low clear.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1_valid_q  <= 1'b0;
      s1_cin_q    <= 1'b0;
      s1_g_q      <= '0;
      s1_p_q      <= '0;
      s1_gg_q     <= '0;
      s1_gp_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_g_q      <= '0;
      s2_p_q      <= '0;
      s2_c_q      <= '0;
      s2_gg_q     <= '0;
      s2_gp_q     <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      gg_out_q    <= '0;
      gp_out_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cin_q    <= s1_cin_d;
      s1_g_q      <= s1_g_d;
      s1_p_q      <= s1_p_d;
      s1_gg_q     <= s1_gg_d;
      s1_gp_q     <= s1_gp_d;
      s2_valid_q  <= s2_valid_d;
      s2_g_q      <= s2_g_d;
      s2_p_q      <= s2_p_d;
      s2_c_q      <= s2_c_d;
      s2_gg_q     <= s2_gg_d;
      s2_gp_q     <= s2_gp_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      gg_out_q    <= gg_out_d;
      gp_out_q    <= gp_out_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cla_group_carry_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cla_group_carry_pipe
//  Purpose  : Self-checking bench for cla_group_carry_pipe. Accepted operands
//             are turned into expected results by an arithmetic model and
//             queued; every output transfer is checked against the queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cla_group_carry_pipe;

  localparam int WIDTH = 16;
  localparam int GROUP = 4;
  localparam int NG    = WIDTH / GROUP;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
  } res_t;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  always #5 CLK = ~CLK;

  cla_group_carry_pipe_if #(.WIDTH(WIDTH), .GROUP(GROUP)) bus ();

  cla_group_carry_pipe #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int   compared   = 0;
  int   mismatched = 0;
  int   acc_count  = 0;
  int   out_count  = 0;
  int   discarded  = 0;
  res_t exp_q[$];
  logic stall_prev = 1'b0;
  res_t held;

  // Exact sum by plain addition; group GG is the carry out of the group's
  // own sum, GP is "group sum is all ones with no carry".
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin);
    res_t          m;
    logic [WIDTH:0] full;
    int            ak, bk, mask;
    full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    m.sum  = full[WIDTH-1:0];
    m.cout = full[WIDTH];
    mask   = (1 << GROUP) - 1;
    m.gg   = '0;
    m.gp   = '0;
    for (int k = 0; k < NG; k++) begin
      ak = int'(a >> (k * GROUP)) & mask;
      bk = int'(b >> (k * GROUP)) & mask;
      m.gg[k] = ((ak + bk) > mask);
      m.gp[k] = ((ak + bk) == mask);
    end
    return m;
  endfunction

  function automatic res_t dut_res();
    res_t r;
    r.sum  = bus.SUM;
    r.cout = bus.COUT;
    r.gg   = bus.GG_OUT;
    r.gp   = bus.GP_OUT;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Input side of the model: every accepted operand pair becomes a result.
  always @(posedge CLK) begin
    if (!RST_N) begin
      discarded += exp_q.size();
      exp_q.delete();
    end else if (bus.IN_VALID && bus.IN_READY) begin
      exp_q.push_back(model(bus.A, bus.B, bus.CIN));
      acc_count++;
    end
  end

  // Compare process: each output transfer against the queue head, and
  // stability of the result while it is being held off.
  always @(negedge CLK) begin
    res_t got, e;
    got = dut_res();
    if (RST_N) begin
      if (stall_prev) begin
        compared++;
        if (!bus.OUT_VALID || got !== held) begin
          mismatched++;
          $display("FAIL hold_stable: got valid=%0b res=0x%0h required valid=1 res=0x%0h",
                   bus.OUT_VALID, got, held);
        end
      end
      if (bus.OUT_VALID && bus.OUT_READY) begin
        compared++;
        out_count++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_output: got res=0x%0h required no output", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            mismatched++;
            $display("FAIL result: got sum=0x%0h cout=%0b gg=%b gp=%b required sum=0x%0h cout=%0b gg=%b gp=%b",
                     got.sum, got.cout, got.gg, got.gp, e.sum, e.cout, e.gg, e.gp);
          end
        end
      end
      stall_prev = bus.OUT_VALID && !bus.OUT_READY;
      held       = got;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge CLK);
      #1;
      if (exp_q.size() == 0 && !bus.OUT_VALID) done = 1'b1;
    end
    chk({name, "_drain_done"}, 64'(done), 64'd1);
  endtask

  task automatic directed(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic [WIDTH-1:0] esum, input logic ecout,
                          input logic [NG-1:0] egg, input logic [NG-1:0] egp);
    bus.A         = a;
    bus.B         = b;
    bus.CIN       = cin;
    bus.IN_VALID  = 1'b1;
    bus.OUT_READY = 1'b1;
    @(negedge CLK);
    chk({name, "_in_ready"}, 64'(bus.IN_READY), 64'd1);
    @(posedge CLK);
    #1;
    bus.IN_VALID = 1'b0;
    @(negedge CLK);
    chk({name, "_c1_valid"}, 64'(bus.OUT_VALID), 64'd0);
    @(posedge CLK);
    @(negedge CLK);
    chk({name, "_c2_valid"}, 64'(bus.OUT_VALID), 64'd0);
    @(posedge CLK);
    @(negedge CLK);
    chk({name, "_c3_valid"}, 64'(bus.OUT_VALID), 64'd1);
    chk({name, "_sum"},  64'(bus.SUM),    64'(esum));
    chk({name, "_cout"}, 64'(bus.COUT),   64'(ecout));
    chk({name, "_gg"},   64'(bus.GG_OUT), 64'(egg));
    chk({name, "_gp"},   64'(bus.GP_OUT), 64'(egp));
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_ops();
    bus.A   = WIDTH'($urandom);
    bus.B   = WIDTH'($urandom);
    bus.CIN = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   base, nr, acc, seen, sent, cyc;
    bit   took;

    bus.IN_VALID  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.CIN       = 1'b0;
    bus.OUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // Reset state
    @(negedge CLK);
    chk("rst_out_valid", 64'(bus.OUT_VALID), 64'd0);
    chk("rst_sum",       64'(bus.SUM),       64'd0);
    chk("rst_cout",      64'(bus.COUT),      64'd0);
    chk("rst_gg",        64'(bus.GG_OUT),    64'd0);
    chk("rst_gp",        64'(bus.GP_OUT),    64'd0);
    chk("rst_in_ready",  64'(bus.IN_READY),  64'd1);
    @(posedge CLK);
    #1;

    // Hand-computed expectations: latency and group vectors
    directed("t1", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 4'b0001, 4'b0010);
    directed("t2", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'b0000, 4'b1111);
    directed("t3", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 4'b1000, 4'b0000);
    drain("directed");

    // Back-to-back stream, full throughput
    base = out_count;
    nr   = 0;
    bus.OUT_READY = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_ops();
      bus.IN_VALID = 1'b1;
      @(negedge CLK);
      if (!bus.IN_READY) nr++;
      @(posedge CLK);
      #1;
    end
    bus.IN_VALID = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("stream_not_ready", 64'(nr), 64'd0);
    chk("stream_throughput", 64'(out_count - base), 64'd100);
    drain("stream");

    // Backpressure: three accepted, then refused, results held stable
    bus.OUT_READY = 1'b0;
    acc = 0;
    rand_ops();
    bus.IN_VALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      took = bus.IN_READY;
      @(posedge CLK);
      #1;
      if (took) begin
        acc++;
        rand_ops();
      end
    end
    @(negedge CLK);
    chk("bp_accepted", 64'(acc), 64'd3);
    chk("bp_in_ready", 64'(bus.IN_READY), 64'd0);
    chk("bp_out_valid", 64'(bus.OUT_VALID), 64'd1);
    @(posedge CLK);
    #1;
    drain("bp");

    // Reset with two results in flight
    base = out_count;
    rand_ops();
    bus.IN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    rand_ops();
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    rand_ops();
    @(posedge CLK);
    #1;
    RST_N        = 1'b1;
    bus.IN_VALID = 1'b0;
    @(negedge CLK);
    chk("mrst_out_valid", 64'(bus.OUT_VALID), 64'd0);
    chk("mrst_sum",       64'(bus.SUM),       64'd0);
    chk("mrst_in_ready",  64'(bus.IN_READY),  64'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (bus.OUT_VALID) seen++;
    end
    chk("mrst_ghosts", 64'(seen), 64'd0);
    chk("mrst_discarded", 64'(discarded), 64'd2);
    @(posedge CLK);
    #1;

    // Random valid/ready toggling
    sent = 0;
    cyc  = 0;
    bus.IN_VALID = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      if (!bus.IN_VALID && $urandom_range(0, 3) != 0) begin
        rand_ops();
        bus.IN_VALID = 1'b1;
      end
      bus.OUT_READY = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      took = bus.IN_VALID && bus.IN_READY;
      @(posedge CLK);
      #1;
      cyc++;
      if (took) begin
        sent++;
        bus.IN_VALID = 1'b0;
      end
    end
    chk("rand_sent", 64'(sent), 64'd10000);
    drain("rand");
    chk("conservation", 64'(out_count + discarded), 64'(acc_count));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
